// File: rtl/prefix_append_packer_pkg.sv
// prefix_append_pkg: shared symbol constants, FSM state type and width helper
package prefix_append_pkg;

    localparam logic [1:0] SYM_PFX10 = 2'b10;
    localparam logic [1:0] SYM_PFX11 = 2'b11;

    typedef enum logic {ACCUM, HOLD} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/prefix_append_packer_if.sv
// prefix_append_packer_if: symbol-in / codeword-out handshake bundle
interface prefix_append_packer_if #(
    parameter int WIDTH = 8,
    parameter int SYM_W = 2
);
    import prefix_append_pkg::*;

    localparam int DEPTH = WIDTH / SYM_W;
    localparam int CNT_W = clog2(DEPTH + 1);

    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] in_sym;
    logic             in_last;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_len;

    modport master (
        output clear, in_valid, in_sym, in_last, flush, out_ready,
        input  in_ready, out_valid, out_data, out_len
    );

    modport slave (
        input  clear, in_valid, in_sym, in_last, flush, out_ready,
        output in_ready, out_valid, out_data, out_len
    );

endinterface

// File: rtl/prefix_append_packer.sv
// prefix_append_packer: prepends symbols at the MSB end of a codeword and emits it when full or closed
module prefix_append_packer
    import prefix_append_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SYM_W = 2
) (
    input logic                  clk,
    input logic                  rst,
    prefix_append_packer_if.slave bus
);

    localparam int DEPTH = WIDTH / SYM_W;
    localparam int CNT_W = clog2(DEPTH + 1);

    state_t           state_q;
    logic [WIDTH-1:0] sreg_q, sreg_d, out_data_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, out_len_q;
    logic             out_valid_q;
    logic             acc, close_acc, close_flush;

    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_len   = out_len_q;

    // Next shift-register/count values for an accepted symbol and the two ways a word closes
    always_comb begin
        acc         = bus.in_valid && (state_q == ACCUM);
        sreg_d      = {bus.in_sym, sreg_q[WIDTH-1:SYM_W]};
        cnt_d       = cnt_q + 1'b1;
        close_acc   = acc && (cnt_d == CNT_W'(DEPTH) || bus.in_last || bus.flush);
        close_flush = !acc && (state_q == ACCUM) && bus.flush && (cnt_q != '0);
    end

    // Packer FSM: accumulate symbols, present the word in HOLD until accepted; clear overrides all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            sreg_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_len_q   <= '0;
        end else if (bus.clear) begin
            state_q     <= ACCUM;
            sreg_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (state_q == ACCUM) begin
            if (acc) begin
                sreg_q <= sreg_d;
                cnt_q  <= cnt_d;
            end
            if (close_acc || close_flush) begin
                state_q     <= HOLD;
                out_valid_q <= 1'b1;
                out_data_q  <= close_acc ? sreg_d : sreg_q;
                out_len_q   <= close_acc ? cnt_d : cnt_q;
            end
        end else if (bus.out_ready) begin
            state_q     <= ACCUM;
            out_valid_q <= 1'b0;
            sreg_q      <= '0;
            cnt_q       <= '0;
        end
    end

endmodule

// File: tb/tb_prefix_append_packer.sv
// tb_prefix_append_packer: directed stimulus with a queue scoreboard checked by an output monitor
module tb_prefix_append_packer;
    import prefix_append_pkg::*;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] l;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    prefix_append_packer_if #(.WIDTH(8), .SYM_W(2)) bus ();

    prefix_append_packer #(.WIDTH(8), .SYM_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completed output handshake is compared against the oldest expected word
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data=%0h len=%0d expected no word", bus.out_data, bus.out_len);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.out_data !== e.d || bus.out_len !== e.l) begin
                    errors++;
                    $display("FAIL word: got data=%0h len=%0d expected data=%0h len=%0d",
                             bus.out_data, bus.out_len, e.d, e.l);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sym, input logic last);
        bus.in_valid = 1'b1;
        bus.in_sym   = sym;
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sym    = 2'b00;
        bus.in_last   = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_len", 32'(bus.out_len), 0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 1);

        // 1: full word 10,11,10,11 -> EE
        sb.push_back('{8'hEE, 3'd4});
        send(SYM_PFX10, 1'b0);
        send(SYM_PFX11, 1'b0);
        send(SYM_PFX10, 1'b0);
        send(SYM_PFX11, 1'b0);
        check("full_out_valid", 32'(bus.out_valid), 1);
        check("full_in_ready_hold", 32'(bus.in_ready), 0);
        tick();
        check("full_released", 32'(bus.out_valid), 0);
        check("full_in_ready_back", 32'(bus.in_ready), 1);

        // 2: early close with in_last -> E0
        sb.push_back('{8'hE0, 3'd2});
        send(SYM_PFX10, 1'b0);
        send(SYM_PFX11, 1'b1);
        check("last_out_valid", 32'(bus.out_valid), 1);
        tick();

        // 3a: flush after one symbol -> C0
        sb.push_back('{8'hC0, 3'd1});
        send(SYM_PFX11, 1'b0);
        tick();
        pulse_flush();
        check("flush_out_valid", 32'(bus.out_valid), 1);
        tick();

        // 3b: flush with empty word is ignored
        pulse_flush();
        check("flush_empty", 32'(bus.out_valid), 0);
        tick();
        check("flush_empty_later", 32'(bus.out_valid), 0);

        // 4: backpressure, word 11,11,11,10 -> BF
        bus.out_ready = 1'b0;
        sb.push_back('{8'hBF, 3'd4});
        send(SYM_PFX11, 1'b0);
        send(SYM_PFX11, 1'b0);
        send(SYM_PFX11, 1'b0);
        send(SYM_PFX10, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_sym   = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_out_valid", 32'(bus.out_valid), 1);
            check("bp_out_data", 32'(bus.out_data), 32'hBF);
            check("bp_out_len", 32'(bus.out_len), 4);
            check("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_released", 32'(bus.out_valid), 0);
        sb.push_back('{8'h80, 3'd1});
        send(SYM_PFX10, 1'b1);
        tick();

        // 5: clear in HOLD and mid-word
        bus.out_ready = 1'b0;
        send(SYM_PFX11, 1'b0);
        send(SYM_PFX11, 1'b0);
        send(SYM_PFX11, 1'b0);
        send(SYM_PFX11, 1'b0);
        check("clr_hold_pre", 32'(bus.out_valid), 1);
        pulse_clear();
        check("clr_hold_valid", 32'(bus.out_valid), 0);
        check("clr_hold_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        send(SYM_PFX11, 1'b0);
        send(SYM_PFX10, 1'b0);
        pulse_clear();
        check("clr_mid_valid", 32'(bus.out_valid), 0);
        check("clr_mid_ready", 32'(bus.in_ready), 1);
        sb.push_back('{8'hFA, 3'd4});
        send(SYM_PFX10, 1'b0);
        send(SYM_PFX10, 1'b0);
        send(SYM_PFX11, 1'b0);
        send(SYM_PFX11, 1'b0);
        check("clr_after_valid", 32'(bus.out_valid), 1);
        tick();

        // 6: async reset mid-clock after two symbols
        send(SYM_PFX10, 1'b0);
        send(SYM_PFX11, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 0);
        check("arst_out_data", 32'(bus.out_data), 0);
        check("arst_out_len", 32'(bus.out_len), 0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_in_ready", 32'(bus.in_ready), 1);
        sb.push_back('{8'hAA, 3'd4});
        send(SYM_PFX10, 1'b0);
        send(SYM_PFX10, 1'b0);
        send(SYM_PFX10, 1'b0);
        send(SYM_PFX10, 1'b0);
        check("arst_word_valid", 32'(bus.out_valid), 1);
        tick();
        tick();
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prefix_append_packer.md
Name: prefix_append_packer

Overview:
- Sequential, parametrised successor to the fixed 2-bit prefix appenders.
- Accepts a stream of SYM_W-bit symbols (e.g. 2'b10, 2'b11) and prepends each one at the MSB end of a WIDTH-bit codeword register.
- Emits the packed codeword with its symbol count when the register is full or a flush is requested.
- Sits between the symbol/code generator and downstream code storage.
- Valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, codeword width in bits; must be an integer multiple of SYM_W.
- SYM_W, 2, bits per prepended symbol.
- DEPTH, WIDTH/SYM_W (derived localparam), symbols per full codeword.
- CNT_W, clog2(DEPTH+1) (derived localparam), width of the symbol counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous, active-high.
- clear  input  1  synchronous abort; discards the partial word and any pending output.
- in_valid  input  1  in_sym is valid.
- in_ready  output  1  block can accept a symbol.
- in_sym  input  SYM_W  symbol to prepend.
- in_last  input  1  qualified by in_valid; close the word after this symbol.
- flush  input  1  close the current partial word without adding a symbol.
- out_valid  output  1  out_data/out_len are valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  packed codeword, MSB-aligned.
- out_len  output  CNT_W  number of valid symbols in out_data (1..DEPTH).

Behaviour:
- Reset (async, rst=1): state=ACCUM, shift register=0, count=0, out_valid=0, out_data=0, out_len=0. in_ready=1 once rst deasserts.
- States:
  - ACCUM: collecting symbols.
  - HOLD: word presented, waiting for out_ready.
- in_ready = (state==ACCUM), purely combinational. No bypass: in_ready=0 throughout HOLD.
- Accept rule: in_valid && in_ready on a clock edge.
  - sreg <= {in_sym, sreg[WIDTH-1:SYM_W]}, so the newest symbol lands in the MSBs and older symbols shift toward the LSB.
  - count <= count+1.
- Close condition, in ACCUM:
  - Accepted symbol with count+1==DEPTH or in_last=1: next cycle state=HOLD, out_valid=1, out_data=updated sreg, out_len=count+1. Latency is 1 cycle from the accepting edge to out_valid.
  - flush=1 with no accepted symbol and count>0: next cycle HOLD, out_data=sreg, out_len=count.
  - flush with count==0 is ignored; no zero-length words are ever emitted.
  - flush together with an accepted symbol: the symbol is included, then the word closes (same as in_last).
- Unfilled low bits of a partial word are 0.
- HOLD:
  - out_data and out_len are stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid<=0, sreg<=0, count<=0, state<=ACCUM.
  - Symbols presented in that same cycle are not accepted (in_ready was 0).
- out_data/out_len keep their last value after the handshake; consumers qualify them with out_valid.
- clear: highest priority below rst.
  - Next cycle: state=ACCUM, sreg=0, count=0, out_valid=0.
  - An in-flight accept or handshake in the same cycle is discarded.
- in_last or flush asserted while in HOLD: ignored.
- count never exceeds DEPTH; wrap-around is impossible because a full word forces HOLD.
- Reset mid-word or mid-HOLD: all state lost and outputs return to reset values immediately (async).

Decomposition:
- Package prefix_append_pkg holds:
  - Symbol constants SYM_PFX10=2'b10 and SYM_PFX11=2'b11.
  - State enum {ACCUM, HOLD}.
  - A clog2 constant function.
- No sub-module. Shift register, counter and FSM live in a single module of about 150 lines.

Test Plan (WIDTH=8, SYM_W=2):
1. Full word, out_ready=1: send 10,11,10,11 on consecutive cycles. Required: out_valid one cycle after the 4th accept, out_data=8'hEE, out_len=4, in_ready=0 during HOLD.
2. Early close: send 10 then 11 with in_last=1. Required: out_data=8'hE0, out_len=2.
3. Flush paths:
   - Send 11, then one cycle later pulse flush. Required: out_data=8'hC0, out_len=1.
   - Pulse flush with count=0. Required: out_valid stays 0.
4. Backpressure: complete a word with out_ready=0 for 3 cycles while in_valid=1. Required: out_data/out_len stable, in_ready=0, no symbol consumed; after out_ready=1, the next word starts from count=0.
5. clear in HOLD and mid-word: each case returns to out_valid=0, count=0, in_ready=1 next cycle. A subsequent 4-symbol word packs correctly.
6. Async reset: assert rst mid-clock after 2 symbols. Required: outputs zero without waiting for a clock edge; a fresh 10,10,10,10 word yields 8'hAA, out_len=4.
